// File: rtl/track_sink_pkg.sv
// Shared state encoding and sizing helpers for the track capture buffer.
package track_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic int unsigned calc_nwords(input int unsigned track_w, input int unsigned word_w);
        return track_w / word_w;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Word-select width; kept at least one bit so a single-word track still has a port.
    function automatic int unsigned calc_wsel_w(input int unsigned track_w, input int unsigned word_w);
        int unsigned nw;
        nw = track_w / word_w;
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/track_buf_ram.sv
// Single-clock simple dual-port track store; registered read without reset, old data on collision.
module track_buf_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/track_capture_buffer.sv
// Orbit-aligned capture buffer for tracklet-output tracks, fill-once or circular.
// Optional BX filter on storage enabled by defining TRACK_BX_FILTER_EN.
module track_capture_buffer
    import track_sink_pkg::*;
#(
    parameter int unsigned TRACK_W = 64,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned BX_W    = 5,
    parameter int unsigned DROP_W  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   BC0,
    input  logic                                   track_en,
    input  logic                                   arm,
    input  logic                                   mode_circ,
`ifdef TRACK_BX_FILTER_EN
    input  logic                                   bx_filter_on,
    input  logic [BX_W-1:0]                        bx_sel,
`endif
    input  logic [TRACK_W-1:0]                     track_output,
    input  logic [calc_aw(DEPTH)-1:0]              rd_addr,
    input  logic [calc_wsel_w(TRACK_W, WORD_W)-1:0] rd_word,
    output logic [WORD_W-1:0]                      rd_data,
    output logic                                   valid_track,
    output logic [BX_W-1:0]                        track_BX,
    output logic [calc_aw(DEPTH)-1:0]              wr_ptr,
    output logic [calc_aw(DEPTH):0]                track_count,
    output logic [DROP_W-1:0]                      drop_count,
    output logic                                   full,
    output logic [1:0]                             state
);

    localparam int unsigned NWORDS = calc_nwords(TRACK_W, WORD_W);
    localparam int unsigned AW     = calc_aw(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned WSEL_W = calc_wsel_w(TRACK_W, WORD_W);
    localparam int unsigned QW     = WORD_W - 8;

    if ((TRACK_W % WORD_W) != 0) begin : g_chk_word
        $error("TRACK_W must be a multiple of WORD_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("DEPTH must be a power of 2");
    end
    if (BX_W > WORD_W) begin : g_chk_bx
        $error("BX_W must not exceed WORD_W");
    end
    if (WORD_W <= 8) begin : g_chk_qual
        $error("WORD_W must exceed 8 for track qualification");
    end

    state_e              state_q, state_d;
    logic [TRACK_W-1:0]  track_dly_q, track_dly_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       track_count_q, track_count_d;
    logic [DROP_W-1:0]   drop_count_q, drop_count_d;
    logic                full_q, full_d;
    logic                mode_circ_q, mode_circ_d;
    logic [WSEL_W-1:0]   rd_word_q, rd_word_d;
    logic                rd_zero_q, rd_zero_d;

    logic                qual_c;
    logic                store_ok_c;
    logic                ram_we_c;
    logic [TRACK_W-1:0]  ram_rdata;

    // A track is qualified when every readout word carries data above its low byte.
    always_comb begin
        qual_c = track_en;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (track_dly_q[w*WORD_W + 8 +: QW] == '0) begin
                qual_c = 1'b0;
            end
        end
    end

    assign valid_track = qual_c;
    assign track_BX    = track_dly_q[TRACK_W-1 -: BX_W];

`ifdef TRACK_BX_FILTER_EN
    assign store_ok_c = qual_c && (!bx_filter_on || (track_BX == bx_sel));
`else
    assign store_ok_c = qual_c;
`endif

    // Capture control: arm overrides everything, including a coincident track.
    always_comb begin
        state_d       = state_q;
        track_dly_d   = track_output;
        wr_ptr_d      = wr_ptr_q;
        track_count_d = track_count_q;
        drop_count_d  = drop_count_q;
        full_d        = full_q;
        mode_circ_d   = mode_circ_q;
        rd_word_d     = rd_word;
        rd_zero_d     = 1'b0;
        ram_we_c      = 1'b0;

        if (arm) begin
            state_d       = ST_ARMED;
            wr_ptr_d      = '0;
            track_count_d = '0;
            drop_count_d  = '0;
            full_d        = 1'b0;
            mode_circ_d   = mode_circ;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (BC0) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (store_ok_c) begin
                        ram_we_c = 1'b1;
                        if (track_count_q != CW'(DEPTH)) begin
                            track_count_d = track_count_q + CW'(1);
                        end
                        if (wr_ptr_q == AW'(DEPTH - 1)) begin
                            full_d = 1'b1;
                            if (mode_circ_q) begin
                                wr_ptr_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            wr_ptr_d = wr_ptr_q + AW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (store_ok_c && (drop_count_q != '1)) begin
                        drop_count_d = drop_count_q + DROP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            track_dly_q   <= '0;
            wr_ptr_q      <= '0;
            track_count_q <= '0;
            drop_count_q  <= '0;
            full_q        <= 1'b0;
            mode_circ_q   <= 1'b0;
            rd_word_q     <= '0;
            rd_zero_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            track_dly_q   <= track_dly_d;
            wr_ptr_q      <= wr_ptr_d;
            track_count_q <= track_count_d;
            drop_count_q  <= drop_count_d;
            full_q        <= full_d;
            mode_circ_q   <= mode_circ_d;
            rd_word_q     <= rd_word_d;
            rd_zero_q     <= rd_zero_d;
        end
    end

    track_buf_ram #(
        .DATA_W (TRACK_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (wr_ptr_q),
        .wdata (track_dly_q),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Word 0 is the most-significant word; output reads as zero right after reset.
    always_comb begin
        rd_data = '0;
        if (!rd_zero_q) begin
            for (int unsigned w = 0; w < NWORDS; w++) begin
                if (rd_word_q == WSEL_W'(w)) begin
                    rd_data = ram_rdata[(NWORDS-1-w)*WORD_W +: WORD_W];
                end
            end
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign track_count = track_count_q;
    assign drop_count  = drop_count_q;
    assign full        = full_q;
    assign state       = state_q;

endmodule

// File: tb/tb_track_capture_buffer.sv
// Self-checking bench for track_capture_buffer (DEPTH=16, DROP_W=4) against a slot/count reference model.
module tb_track_capture_buffer;

    localparam int D = 16;

    logic        clk;
    logic        reset, BC0, track_en, arm, mode_circ;
    logic [63:0] track_output;
    logic [3:0]  rd_addr;
    logic [0:0]  rd_word;
    logic [31:0] rd_data;
    logic        valid_track;
    logic [4:0]  track_BX;
    logic [3:0]  wr_ptr;
    logic [4:0]  track_count;
    logic [3:0]  drop_count;
    logic        full;
    logic [1:0]  state;
`ifdef TRACK_BX_FILTER_EN
    logic        bx_filter_on;
    logic [4:0]  bx_sel;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase code, writes since arm, drops, and the expected RAM image.
    int          m_phase, m_n, m_drops;
    bit          m_circ;
    logic [63:0] m_mem [D];
    bit          m_written [D];
    logic [63:0] tb_dly;

    track_capture_buffer #(
        .TRACK_W (64), .WORD_W (32), .DEPTH (D), .BX_W (5), .DROP_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .BC0          (BC0),
        .track_en     (track_en),
        .arm          (arm),
        .mode_circ    (mode_circ),
`ifdef TRACK_BX_FILTER_EN
        .bx_filter_on (bx_filter_on),
        .bx_sel       (bx_sel),
`endif
        .track_output (track_output),
        .rd_addr      (rd_addr),
        .rd_word      (rd_word),
        .rd_data      (rd_data),
        .valid_track  (valid_track),
        .track_BX     (track_BX),
        .wr_ptr       (wr_ptr),
        .track_count  (track_count),
        .drop_count   (drop_count),
        .full         (full),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_qual(input logic [63:0] t);
        logic [31:0] hi, lo;
        hi = t[63:32];
        lo = t[31:0];
        return (hi >= 32'd256) && (lo >= 32'd256);
    endfunction

    function automatic bit bx_pass(input logic [63:0] t);
`ifdef TRACK_BX_FILTER_EN
        if (bx_filter_on) return (t[63:59] == bx_sel);
`endif
        return 1'b1;
    endfunction

    function automatic int exp_count();
        return (m_n < D) ? m_n : D;
    endfunction

    function automatic bit exp_full();
        return m_n >= D;
    endfunction

    function automatic int exp_ptr();
        if (m_circ) return m_n % D;
        return (m_n >= D) ? D - 1 : m_n;
    endfunction

    function automatic logic [63:0] rand_trk(input bit good);
        logic [31:0] hi, lo;
        hi = $urandom | 32'h0000_0100;
        lo = $urandom | 32'h0000_0100;
        if (!good) begin
            if ($urandom_range(1, 0) == 1) hi = hi & 32'h0000_00FF;
            else lo = lo & 32'h0000_00FF;
        end
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_drops = 0; m_circ = 1'b0; tb_dly = '0;
    endtask

    // The track judged in a cycle is the one presented on the bus the cycle before.
    task automatic model_cycle(input bit a, input bit b, input bit en, input logic [63:0] dly, input bit circ);
        bit ok;
        int slot;
        ok = en && is_qual(dly) && bx_pass(dly);
        if (a) begin
            m_phase = 1; m_n = 0; m_drops = 0; m_circ = circ;
        end else begin
            case (m_phase)
                1: if (b) m_phase = 2;
                2: if (ok) begin
                    slot = m_circ ? (m_n % D) : m_n;
                    m_mem[slot] = dly;
                    m_written[slot] = 1'b1;
                    m_n++;
                    if (!m_circ && m_n == D) m_phase = 3;
                end
                3: if (ok && m_drops < 15) m_drops++;
                default: ;
            endcase
        end
    endtask

    task automatic drive_cycle(input bit a, input bit b, input bit en, input logic [63:0] trk);
        arm = a; BC0 = b; track_en = en; track_output = trk;
        model_cycle(a, b, en, tb_dly, mode_circ);
        @(posedge clk);
        #1;
        tb_dly = trk;
        arm = 1'b0; BC0 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; BC0 = 1'b0; track_output = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", wr_ptr); end
        n_checks++; if (track_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", track_count); end
        n_checks++; if (drop_count !== 4'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_checks++; if (valid_track !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_track); end
    endtask

    task automatic test_basic();
        logic [63:0] t;
        t = 64'h1234_5600_ABCD_EF00;
        mode_circ = 1'b0;
        drive_cycle(1, 0, 1, '0);
        drive_cycle(0, 1, 1, t);
        drive_cycle(0, 0, 1, t);
        drive_cycle(0, 0, 1, t);
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (track_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", track_count); end
        n_checks++; if (wr_ptr !== 4'd3) begin n_fail++; $display("FAIL basic_ptr: got %0d want 3", wr_ptr); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL basic_state: got %0d want 2", state); end
        rd_addr = 4'd2; rd_word = 1'b1;
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (rd_data !== 32'hABCD_EF00) begin n_fail++; $display("FAIL basic_rd_w1: got %h want abcdef00", rd_data); end
        rd_word = 1'b0;
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (rd_data !== 32'h1234_5600) begin n_fail++; $display("FAIL basic_rd_w0: got %h want 12345600", rd_data); end
    endtask

    task automatic test_qualify();
        logic [63:0] good;
        good = 64'h0AAA_0100_0BBB_0200;
        drive_cycle(0, 0, 1, 64'h1234_5600_0000_00FF);
        n_checks++; if (valid_track !== 1'b0) begin n_fail++; $display("FAIL qual_low_word: got %0b want 0", valid_track); end
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (track_count !== 5'd3) begin n_fail++; $display("FAIL qual_no_write: got %0d want 3", track_count); end
        drive_cycle(0, 0, 0, good);
        n_checks++; if (valid_track !== 1'b0) begin n_fail++; $display("FAIL qual_en_low: got %0b want 0", valid_track); end
        drive_cycle(0, 0, 0, '0);
        n_checks++; if (track_count !== 5'd3) begin n_fail++; $display("FAIL qual_en_no_write: got %0d want 3", track_count); end
        drive_cycle(0, 0, 1, good);
        n_checks++; if (valid_track !== 1'b1) begin n_fail++; $display("FAIL qual_good: got %0b want 1", valid_track); end
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (track_count !== 5'd4) begin n_fail++; $display("FAIL qual_stored: got %0d want 4", track_count); end
    endtask

    task automatic test_fill_once();
        logic [63:0] hist [20];
        mode_circ = 1'b0;
        drive_cycle(1, 0, 1, '0);
        drive_cycle(0, 1, 1, '0);
        for (int i = 0; i < 20; i++) begin
            hist[i] = rand_trk(1'b1);
            drive_cycle(0, 0, 1, hist[i]);
        end
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL fill_state: got %0d want 3", state); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b want 1", full); end
        n_checks++; if (track_count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d want 16", track_count); end
        n_checks++; if (drop_count !== 4'd4) begin n_fail++; $display("FAIL fill_drop: got %0d want 4", drop_count); end
        n_checks++; if (wr_ptr !== 4'd15) begin n_fail++; $display("FAIL fill_ptr: got %0d want 15", wr_ptr); end
        for (int w = 0; w < 2; w++) begin
            rd_addr = 4'd15; rd_word = 1'(w);
            drive_cycle(0, 0, 1, '0);
            n_checks++;
            if (rd_data !== ((w == 0) ? hist[15][63:32] : hist[15][31:0])) begin
                n_fail++; $display("FAIL fill_ram15_w%0d: got %h want %h", w, rd_data, (w == 0) ? hist[15][63:32] : hist[15][31:0]);
            end
        end
    endtask

    task automatic test_drop_sat();
        drive_cycle(0, 1, 1, rand_trk(1'b1));
        for (int i = 0; i < 14; i++) drive_cycle(0, 0, 1, rand_trk(1'b1));
        drive_cycle(0, 1, 1, '0);
        n_checks++; if (drop_count !== 4'd15) begin n_fail++; $display("FAIL drop_saturate: got %0d want 15", drop_count); end
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL drop_bc0_in_done: got %0d want 3", state); end
    endtask

    task automatic test_circular();
        logic [63:0] hist [20];
        mode_circ = 1'b1;
        drive_cycle(1, 0, 1, '0);
        drive_cycle(0, 1, 1, '0);
        for (int i = 0; i < 20; i++) begin
            hist[i] = rand_trk(1'b1);
            drive_cycle(0, 0, 1, hist[i]);
        end
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL circ_full: got %0b want 1", full); end
        n_checks++; if (wr_ptr !== 4'd4) begin n_fail++; $display("FAIL circ_ptr: got %0d want 4", wr_ptr); end
        n_checks++; if (track_count !== 5'd16) begin n_fail++; $display("FAIL circ_count: got %0d want 16", track_count); end
        n_checks++; if (drop_count !== 4'd0) begin n_fail++; $display("FAIL circ_drop: got %0d want 0", drop_count); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL circ_state: got %0d want 2", state); end
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                rd_addr = 4'(s); rd_word = 1'(w);
                drive_cycle(0, 0, 1, '0);
                n_checks++;
                if (rd_data !== ((w == 0) ? hist[16+s][63:32] : hist[16+s][31:0])) begin
                    n_fail++; $display("FAIL circ_ram%0d_w%0d: got %h want %h", s, w, rd_data, (w == 0) ? hist[16+s][63:32] : hist[16+s][31:0]);
                end
            end
        end
        mode_circ = 1'b0;
    endtask

    task automatic test_armed_ignore();
        logic [63:0] t;
        t = rand_trk(1'b1);
        mode_circ = 1'b0;
        drive_cycle(1, 0, 1, '0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, t);
        drive_cycle(0, 1, 1, '0);
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (track_count !== 5'd0) begin n_fail++; $display("FAIL armed_count: got %0d want 0", track_count); end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL armed_ptr: got %0d want 0", wr_ptr); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL armed_to_capture: got %0d want 2", state); end
        drive_cycle(0, 0, 1, t);
        drive_cycle(0, 1, 1, t);
        drive_cycle(0, 0, 1, t);
        n_checks++; if (track_count !== 5'd2) begin n_fail++; $display("FAIL capture_bc0_noeffect: got %0d want 2", track_count); end
        drive_cycle(1, 0, 1, '0);
        n_checks++; if (track_count !== 5'd0) begin n_fail++; $display("FAIL arm_wins_count: got %0d want 0", track_count); end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL arm_wins_ptr: got %0d want 0", wr_ptr); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL arm_wins_state: got %0d want 1", state); end
    endtask

    task automatic test_reset_midway();
        logic [63:0] t;
        mode_circ = 1'b0;
        drive_cycle(1, 0, 1, '0);
        drive_cycle(0, 1, 1, '0);
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, 1, rand_trk(1'b1));
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (track_count !== 5'd5) begin n_fail++; $display("FAIL mid_count5: got %0d want 5", track_count); end
        do_reset();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d want 0", state); end
        n_checks++; if (track_count !== 5'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", track_count); end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL mid_reset_ptr: got %0d want 0", wr_ptr); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL mid_reset_rd: got %h want 0", rd_data); end
        t = rand_trk(1'b1);
        drive_cycle(1, 0, 1, '0);
        drive_cycle(0, 1, 1, t);
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (wr_ptr !== 4'd1) begin n_fail++; $display("FAIL mid_rearm_ptr: got %0d want 1", wr_ptr); end
        rd_addr = 4'd0; rd_word = 1'b1;
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (rd_data !== t[31:0]) begin n_fail++; $display("FAIL mid_rearm_ram0: got %h want %h", rd_data, t[31:0]); end
    endtask

`ifdef TRACK_BX_FILTER_EN
    task automatic test_bx_filter();
        logic [63:0] t;
        int n3;
        n3 = 0;
        bx_filter_on = 1'b1; bx_sel = 5'd3; mode_circ = 1'b0;
        drive_cycle(1, 0, 1, '0);
        drive_cycle(0, 1, 1, '0);
        for (int i = 0; i < 12; i++) begin
            t = rand_trk(1'b1);
            t[63:59] = ($urandom_range(1, 0) == 1) ? 5'd3 : 5'(4 + $urandom_range(20, 0));
            if (t[63:59] == 5'd3) n3++;
            drive_cycle(0, 0, 1, t);
            n_checks++; if (valid_track !== 1'b1) begin n_fail++; $display("FAIL bx_valid_unaffected: got %0b want 1", valid_track); end
        end
        drive_cycle(0, 0, 1, '0);
        n_checks++; if (track_count !== 5'(n3)) begin n_fail++; $display("FAIL bx_count: got %0d want %0d", track_count, n3); end
        bx_filter_on = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [63:0] t;
        logic [31:0] exp_rd;
        bit          a, b, en, rd_ok;
        for (int i = 0; i < 800; i++) begin
            a  = ($urandom_range(49, 0) == 0);
            b  = ($urandom_range(7, 0) == 0);
            en = ($urandom_range(9, 0) != 0);
            t  = rand_trk($urandom_range(9, 0) < 7);
            if (a) mode_circ = 1'($urandom_range(1, 0));
            rd_addr = 4'($urandom_range(D - 1, 0));
            rd_word = 1'($urandom_range(1, 0));
            rd_ok   = m_written[rd_addr];
            exp_rd  = (rd_word == 1'b0) ? m_mem[rd_addr][63:32] : m_mem[rd_addr][31:0];
            drive_cycle(a, b, en, t);
            n_checks++; if (state !== 2'(m_phase)) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d want %0d", i, state, m_phase); end
            n_checks++; if (wr_ptr !== 4'(exp_ptr())) begin n_fail++; $display("FAIL rnd_ptr@%0d: got %0d want %0d", i, wr_ptr, exp_ptr()); end
            n_checks++; if (track_count !== 5'(exp_count())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, track_count, exp_count()); end
            n_checks++; if (drop_count !== 4'(m_drops)) begin n_fail++; $display("FAIL rnd_drop@%0d: got %0d want %0d", i, drop_count, m_drops); end
            n_checks++; if (full !== exp_full()) begin n_fail++; $display("FAIL rnd_full@%0d: got %0b want %0b", i, full, exp_full()); end
            n_checks++; if (valid_track !== (en && is_qual(t))) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, valid_track, en && is_qual(t)); end
            n_checks++; if (track_BX !== t[63:59]) begin n_fail++; $display("FAIL rnd_bx@%0d: got %0d want %0d", i, track_BX, t[63:59]); end
            if (rd_ok) begin
                n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL rnd_rd@%0d: got %h want %h", i, rd_data, exp_rd); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; BC0 = 1'b0; track_en = 1'b0; arm = 1'b0; mode_circ = 1'b0;
        track_output = '0; rd_addr = '0; rd_word = '0;
`ifdef TRACK_BX_FILTER_EN
        bx_filter_on = 1'b0; bx_sel = '0;
`endif
        for (int s = 0; s < D; s++) begin
            m_written[s] = 1'b0;
            m_mem[s] = '0;
        end
        test_reset();
        test_basic();
        test_qualify();
        test_fill_once();
        test_drop_sat();
        test_circular();
        test_armed_ignore();
        test_reset_midway();
`ifdef TRACK_BX_FILTER_EN
        test_bx_filter();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
